// File: rtl/stack_pointer_register.sv
// Stack pointer register: loadable pointer with bounded push/pop steps,
// sticky overflow/underflow flags, a one-cycle error pulse and full/empty status.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous reset, active-low
//   in          load value, taken when write=1
//   write       load enable; has priority over push/pop
//   push        push request (step toward LIMIT_LO when GROW_DOWN=1)
//   pop         pop request (opposite direction to push)
//   clear_flags clears overflow/underflow; a same-edge rejection wins
//   out         registered pointer value
//   overflow    sticky, set by a rejected push
//   underflow   sticky, set by a rejected pop
//   error       registered pulse for the cycle after a rejected push or pop
//   full        high when a push at the current out would be rejected
//   empty       high when a pop at the current out would be rejected
module stack_pointer_register #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0100,
  parameter logic [WIDTH-1:0] STEP        = 16'd1,
  parameter logic [WIDTH-1:0] LIMIT_LO    = 16'd0,
  parameter logic [WIDTH-1:0] LIMIT_HI    = 16'h0100,
  parameter bit               GROW_DOWN   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             write,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             underflow,
  output logic             error,
  output logic             full,
  output logic             empty
);

  // Two guard bits: bit WIDTH carries out of an add, and a borrow
  // from a subtract sets both guard bits, so either shows as nonzero.
  localparam int unsigned XW = WIDTH + 2;

  localparam logic [XW-1:0] STEP_X = {2'b00, STEP};
  localparam logic [XW-1:0] LO_X   = {2'b00, LIMIT_LO};
  localparam logic [XW-1:0] HI_X   = {2'b00, LIMIT_HI};

  logic [WIDTH-1:0] r_out;
  logic             r_ovf;
  logic             r_unf;
  logic             r_err;

  logic [XW-1:0] w_out_x;
  logic [XW-1:0] w_inc;
  logic [XW-1:0] w_dec;
  logic [XW-1:0] w_push_cand;
  logic [XW-1:0] w_pop_cand;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Range test by sign of differences, so a limit of zero or all-ones
  // needs no special casing.
  function automatic logic f_ok(input logic [XW-1:0] c);
    logic [XW-1:0] d_lo;
    logic [XW-1:0] d_hi;
    d_lo = c - LO_X;
    d_hi = HI_X - c;
    return (c[XW-1:WIDTH] == 2'b00) && !d_lo[XW-1] && !d_hi[XW-1];
  endfunction

  assign w_out_x     = {2'b00, r_out};
  assign w_inc       = w_out_x + STEP_X;
  assign w_dec       = w_out_x - STEP_X;
  assign w_push_cand = GROW_DOWN ? w_dec : w_inc;
  assign w_pop_cand  = GROW_DOWN ? w_inc : w_dec;
  assign w_push_ok   = f_ok(w_push_cand);
  assign w_pop_ok    = f_ok(w_pop_cand);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out <= RESET_VALUE;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (write) begin
        r_out <= in;
      end else begin
        if (clear_flags) begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end
        // Later assignments override the clear, so a rejection wins.
        if (push && !pop) begin
          if (w_push_ok) begin
            r_out <= w_push_cand[WIDTH-1:0];
          end else begin
            r_ovf <= 1'b1;
            r_err <= 1'b1;
          end
        end else if (pop && !push) begin
          if (w_pop_ok) begin
            r_out <= w_pop_cand[WIDTH-1:0];
          end else begin
            r_unf <= 1'b1;
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign out       = r_out;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign error     = r_err;
  assign full      = !w_push_ok;
  assign empty     = !w_pop_ok;

endmodule

// File: tb/tb_stack_pointer_register.sv
// Bench for stack_pointer_register: two instances (default and an
// upward-growing narrow-window variant) against an integer model.
module tb_stack_pointer_register;

  typedef struct {
    int out;
    bit ovf;
    bit unf;
    bit err;
  } st_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] din [2];
  logic        wr  [2];
  logic        pu  [2];
  logic        po  [2];
  logic        cl  [2];
  logic [15:0] q   [2];
  logic        ovf [2];
  logic        unf [2];
  logic        err [2];
  logic        ful [2];
  logic        emp [2];

  st_t m [2];
  int  p_step [2] = '{1, 2};
  int  p_lo   [2] = '{0, 'h100};
  int  p_hi   [2] = '{'h100, 'h102};
  bit  p_down [2] = '{1'b1, 1'b0};
  int  p_rst  [2] = '{'h100, 'h100};

  int n_checks = 0;
  int n_errors = 0;

  stack_pointer_register u_dut_a (
    .clock(clk), .reset(rst_n), .in(din[0]), .write(wr[0]),
    .push(pu[0]), .pop(po[0]), .clear_flags(cl[0]), .out(q[0]),
    .overflow(ovf[0]), .underflow(unf[0]), .error(err[0]),
    .full(ful[0]), .empty(emp[0])
  );

  stack_pointer_register #(
    .WIDTH(16), .RESET_VALUE(16'h0100), .STEP(16'd2),
    .LIMIT_LO(16'h0100), .LIMIT_HI(16'h0102), .GROW_DOWN(1'b0)
  ) u_dut_b (
    .clock(clk), .reset(rst_n), .in(din[1]), .write(wr[1]),
    .push(pu[1]), .pop(po[1]), .clear_flags(cl[1]), .out(q[1]),
    .overflow(ovf[1]), .underflow(unf[1]), .error(err[1]),
    .full(ful[1]), .empty(emp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(int c, int lo, int hi);
    return c >= 0 && c <= 65535 && c >= lo && c <= hi;
  endfunction

  function automatic int push_to(int i, int v);
    return p_down[i] ? v - p_step[i] : v + p_step[i];
  endfunction

  function automatic int pop_to(int i, int v);
    return p_down[i] ? v + p_step[i] : v - p_step[i];
  endfunction

  function automatic st_t rst_state(int i);
    st_t s;
    s.out = p_rst[i];
    s.ovf = 0;
    s.unf = 0;
    s.err = 0;
    return s;
  endfunction

  function automatic st_t step(int i, st_t s);
    st_t n;
    int  c;
    n = s;
    n.err = 0;
    if (wr[i]) begin
      n.out = int'(din[i]);
    end else begin
      if (cl[i]) begin
        n.ovf = 0;
        n.unf = 0;
      end
      if (pu[i] && !po[i]) begin
        c = push_to(i, s.out);
        if (legal(c, p_lo[i], p_hi[i])) n.out = c;
        else begin
          n.ovf = 1;
          n.err = 1;
        end
      end else if (po[i] && !pu[i]) begin
        c = pop_to(i, s.out);
        if (legal(c, p_lo[i], p_hi[i])) n.out = c;
        else begin
          n.unf = 1;
          n.err = 1;
        end
      end
    end
    return n;
  endfunction

  task automatic check_all(input string tag);
    bit f;
    bit e;
    for (int i = 0; i < 2; i++) begin
      f = !legal(push_to(i, m[i].out), p_lo[i], p_hi[i]);
      e = !legal(pop_to(i, m[i].out), p_lo[i], p_hi[i]);
      chk($sformatf("%s.%0d.out", tag, i), 32'(q[i]), 32'(m[i].out));
      chk($sformatf("%s.%0d.ovf", tag, i), 32'(ovf[i]), 32'(m[i].ovf));
      chk($sformatf("%s.%0d.unf", tag, i), 32'(unf[i]), 32'(m[i].unf));
      chk($sformatf("%s.%0d.err", tag, i), 32'(err[i]), 32'(m[i].err));
      chk($sformatf("%s.%0d.full", tag, i), 32'(ful[i]), 32'(f));
      chk($sformatf("%s.%0d.empty", tag, i), 32'(emp[i]), 32'(e));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      m[i] = rst_n ? step(i, m[i]) : rst_state(i);
    check_all(tag);
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      wr[i] = 0; pu[i] = 0; po[i] = 0; cl[i] = 0; din[i] = '0;
    end
  endtask

  function automatic logic [15:0] pick(int i);
    logic [15:0] t [6];
    if (i == 0) t = '{16'h0000, 16'h0100, 16'h0080, 16'hFFFF, 16'h0101, 16'h0001};
    else        t = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h00FF, 16'hFFFF};
    if ($urandom_range(0, 6) == 6) return 16'($urandom);
    return t[$urandom_range(0, 5)];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    m[0] = rst_state(0);
    m[1] = rst_state(1);
    tick("rst");
    tick("rst");
    rst_n = 1'b1;

    tick("idle");
    chk("r34.out", 32'(q[0]), 32'h0100);
    chk("r34.empty", 32'(emp[0]), 32'd1);
    chk("r34.full", 32'(ful[0]), 32'd0);

    pu[0] = 1;
    tick("push1"); chk("r35.p1", 32'(q[0]), 32'h00FF);
    tick("push2"); chk("r35.p2", 32'(q[0]), 32'h00FE);
    tick("push3"); chk("r35.p3", 32'(q[0]), 32'h00FD);
    pu[0] = 0; po[0] = 1;
    tick("pop1");  chk("r35.pop", 32'(q[0]), 32'h00FE);
    chk("r35.err", 32'(err[0]), 32'd0);
    idle();

    wr[0] = 1; din[0] = 16'h0000;
    tick("ld0");
    wr[0] = 0; pu[0] = 1;
    tick("ovf");
    chk("r36.out", 32'(q[0]), 32'h0000);
    chk("r36.ovf", 32'(ovf[0]), 32'd1);
    chk("r36.err", 32'(err[0]), 32'd1);
    pu[0] = 0;
    tick("ovf2");
    chk("r36.err0", 32'(err[0]), 32'd0);
    cl[0] = 1;
    tick("clr");
    chk("r36.clr", 32'(ovf[0]), 32'd0);
    idle();

    wr[0] = 1; din[0] = 16'h0100;
    tick("ld100");
    wr[0] = 0; po[0] = 1;
    tick("unf");
    chk("r37.out", 32'(q[0]), 32'h0100);
    chk("r37.unf", 32'(unf[0]), 32'd1);
    po[0] = 0; wr[0] = 1; din[0] = 16'h0080;
    tick("ld80");
    wr[0] = 0; pu[0] = 1; po[0] = 1;
    tick("both");
    chk("r37.both", 32'(q[0]), 32'h0080);
    chk("r37.berr", 32'(err[0]), 32'd0);
    po[0] = 0; wr[0] = 1; din[0] = 16'h0040;
    tick("wrpush");
    chk("r37.wr", 32'(q[0]), 32'h0040);
    idle();

    wr[0] = 1; din[0] = 16'h0000;
    tick("ld0b");
    wr[0] = 0; pu[0] = 1;
    tick("ovfb");
    pu[0] = 0; wr[0] = 1; din[0] = 16'h0010;
    tick("ld10");
    chk("r38.pre", 32'(q[0]), 32'h0010);
    rst_n = 1'b0;
    #2;
    m[0] = rst_state(0);
    m[1] = rst_state(1);
    check_all("arst");
    chk("r38.out", 32'(q[0]), 32'h0100);
    chk("r38.ovf", 32'(ovf[0]), 32'd0);
    din[0] = 16'h0055;
    pu[1] = 1;
    tick("rsthold");
    #2;
    rst_n = 1'b1;
    idle();
    pu[0] = 1;
    tick("first");
    chk("r33.first", 32'(q[0]), 32'h00FF);
    idle();

    pu[1] = 1;
    tick("b.p1"); chk("r39.p1", 32'(q[1]), 32'h0102);
    tick("b.p2"); chk("r39.ovf", 32'(ovf[1]), 32'd1);
    chk("r39.hold", 32'(q[1]), 32'h0102);
    pu[1] = 0; po[1] = 1;
    tick("b.q1"); chk("r39.q1", 32'(q[1]), 32'h0100);
    tick("b.q2"); chk("r39.unf", 32'(unf[1]), 32'd1);
    idle();

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < 2; i++) begin
        wr[i]  = ($urandom_range(0, 15) == 0);
        din[i] = pick(i);
        pu[i]  = ($urandom_range(0, 2) == 0);
        po[i]  = ($urandom_range(0, 2) == 0);
        cl[i]  = ($urandom_range(0, 9) == 0);
      end
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
